// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu boot/run controller.
package cpu_ctrl_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_SHIFT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/pc_loop_detect.sv
// Flags a cpu that has presented the same pc for LOOP_DETECT consecutive run cycles.
module pc_loop_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned LOOP_DETECT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] pc,
    output logic              loop
);

    localparam int unsigned CNT_W = $clog2(LOOP_DETECT + 1);
    localparam logic [CNT_W-1:0] LOOP_MAX = CNT_W'(LOOP_DETECT);

    logic [WORD_W-1:0] last_pc;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  run_len_next;

    // run_len == 0 means no pc has been seen since the last clear
    always_comb begin
        run_len_next = CNT_W'(1);
        if (run_len != '0 && pc == last_pc) begin
            run_len_next = (run_len >= LOOP_MAX) ? run_len : run_len + CNT_W'(1);
        end
        loop = enable && (run_len_next >= LOOP_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_pc <= '0;
            run_len <= '0;
        end else if (clear) begin
            run_len <= '0;
        end else if (enable) begin
            last_pc <= pc;
            run_len <= run_len_next;
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot and run sequencer: streams a program into imem while the cpu is held in reset,
// then releases the cpu and watches its pc for a halt address, a self-loop or budget expiry.
module cpu_boot_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_WORDS     = 64,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned MAX_RUN_CYCLES = 1024,
    parameter int unsigned LOOP_DETECT    = 4,
    localparam int unsigned IDX_W         = $clog2(IMEM_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    input  logic [WORD_W-1:0] halt_addr,
    output logic              imem_we,
    output logic [IDX_W-1:0]  imem_widx,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic [WORD_W-1:0] cpu_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [WORD_W-1:0] run_cycles
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // A zero setting still spends one cycle in SETTLE so the last imem write lands
    localparam logic [SET_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 1) ? SET_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [WORD_W-1:0] IMEM_LIMIT = WORD_W'(IMEM_WORDS);
    localparam logic [WORD_W-1:0] RUN_LIMIT  = WORD_W'(MAX_RUN_CYCLES);

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic              handshake;
    logic              addr_ok;
    logic              pc_hit;
    logic              loop_hit;
    logic              budget_hit;
    logic              loop_clear;
    logic              run_en;
    logic [WORD_W-1:0] run_next;

    always_comb begin
        load_ready = (state == LOAD);
        handshake  = load_valid && load_ready;
        addr_ok    = (load_addr[BYTE_SHIFT-1:0] == '0) &&
                     ((load_addr >> BYTE_SHIFT) < IMEM_LIMIT);
        run_next   = (run_cycles == '1) ? run_cycles : run_cycles + WORD_W'(1);
        pc_hit     = (cpu_pc == halt_addr);
        budget_hit = (run_next >= RUN_LIMIT);
        loop_clear = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
        run_en     = (state == RUN);
        cpu_reset  = (state != RUN);
        busy       = (state == LOAD) || (state == SETTLE) || (state == RUN);
        done       = (state == DONE);
    end

    pc_loop_detect #(
        .LOOP_DETECT(LOOP_DETECT)
    ) u_loop_detect (
        .clock (clock),
        .reset (reset),
        .clear (loop_clear),
        .enable(run_en),
        .pc    (cpu_pc),
        .loop  (loop_hit)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            imem_we    <= 1'b0;
            imem_widx  <= '0;
            imem_wdata <= '0;
            timeout    <= 1'b0;
            load_err   <= 1'b0;
            run_cycles <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        timeout    <= 1'b0;
                        load_err   <= 1'b0;
                        run_cycles <= '0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (addr_ok) begin
                            imem_we    <= 1'b1;
                            imem_widx  <= load_addr[BYTE_SHIFT +: IDX_W];
                            imem_wdata <= load_data;
                        end else begin
                            load_err <= 1'b1;
                        end
                        if (load_last) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                RUN: begin
                    run_cycles <= run_next;
                    // halt and loop outrank the budget, so a coincident halt is not a timeout
                    if (pc_hit || loop_hit) begin
                        state <= DONE;
                    end else if (budget_hit) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Scoreboard bench for cpu_boot_ctrl: a behavioural cpu drives cpu_pc, expected imem writes
// and run outcomes are queued by the stimulus and checked by an independent monitor.
module tb_cpu_boot_ctrl;

    localparam int unsigned IMEM_WORDS = 64;
    localparam int unsigned SETTLE     = 2;
    localparam int unsigned MAX_RUN    = 32;
    localparam int unsigned LOOP       = 4;
    localparam int unsigned IDX_W      = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_last = 1'b0;
    logic [31:0]       load_addr = '0;
    logic [31:0]       load_data = '0;
    logic [31:0]       halt_addr = '0;
    logic [31:0]       cpu_pc;
    logic              load_ready, imem_we, cpu_reset, busy, done, timeout, load_err;
    logic [IDX_W-1:0]  imem_widx;
    logic [31:0]       imem_wdata, run_cycles;

    cpu_boot_ctrl #(
        .IMEM_WORDS    (IMEM_WORDS),
        .SETTLE_CYCLES (SETTLE),
        .MAX_RUN_CYCLES(MAX_RUN),
        .LOOP_DETECT   (LOOP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_last (load_last),
        .halt_addr (halt_addr),
        .imem_we   (imem_we),
        .imem_widx (imem_widx),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .cpu_pc    (cpu_pc),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .load_err  (load_err),
        .run_cycles(run_cycles)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural cpu: mode 0 walks pc forward by 4, mode 1 spins at address 0
    int          mode = 0;
    logic [31:0] pc_q = '0;
    always @(posedge clock) begin
        if (cpu_reset) pc_q <= '0;
        else if (mode == 0) pc_q <= pc_q + 32'd4;
    end
    assign cpu_pc = pc_q;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } wr_t;
    typedef struct {
        int cycles;
        bit to;
        bit err;
    } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    wr_t  wr_e;
    res_t rs_e;
    bit   exp_err = 1'b0;
    bit   check_settle = 1'b0;
    int   exp_last_cyc = 0;
    logic [31:0] prog_a[$];
    logic [31:0] prog_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a completion
    logic done_d = 1'b0;
    logic cpu_reset_d = 1'b1;
    always @(negedge clock) begin
        if (reset) begin
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got write idx %0d data 0x%0h, expected none",
                             imem_widx, imem_wdata);
                end else begin
                    wr_e = exp_wr.pop_front();
                    chk("wr_idx", 32'(imem_widx), 32'(wr_e.idx));
                    chk("wr_data", imem_wdata, wr_e.data);
                end
            end
            if (cpu_reset_d && !cpu_reset && check_settle) begin
                chk("settle_len", 32'(cyc - exp_last_cyc), SETTLE);
                check_settle = 1'b0;
            end
            if (done && !done_d) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1, expected no completion");
                end else begin
                    rs_e = exp_res.pop_front();
                    chk("run_cycles", run_cycles, 32'(rs_e.cycles));
                    chk("timeout", 32'(timeout), 32'(rs_e.to));
                    chk("load_err", 32'(load_err), 32'(rs_e.err));
                    chk("cpu_reset_done", 32'(cpu_reset), 32'd1);
                end
            end
        end
        done_d <= done;
        cpu_reset_d <= cpu_reset;
    end

    // Reference: first RUN cycle where pc hits halt, repeats LOOP times, or the budget ends
    function automatic void predict(input int m, input logic [31:0] halt,
                                    output int k, output bit to);
        logic [31:0] pc, prev;
        int same;
        same = 0;
        prev = '0;
        to = 1'b0;
        k = MAX_RUN;
        for (int i = 1; i <= int'(MAX_RUN); i++) begin
            pc = (m == 0) ? 32'(4 * (i - 1)) : 32'd0;
            same = (i > 1 && pc == prev) ? same + 1 : 1;
            prev = pc;
            if (pc == halt || same >= int'(LOOP)) begin
                k = i;
                return;
            end
            if (i == int'(MAX_RUN)) begin
                k = i;
                to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit last,
                        input int gap);
        load_valid = 1'b0;
        repeat (gap) @(negedge clock);
        load_valid = 1'b1;
        load_addr = a;
        load_data = d;
        load_last = last;
        #1;
        chk("load_ready", 32'(load_ready), 32'd1);
        if (a[1:0] == 2'b00 && a < IMEM_WORDS * 4) exp_wr.push_back('{a[7:2], d});
        else exp_err = 1'b1;
        if (last) begin
            exp_last_cyc = cyc + 1;
            check_settle = 1'b1;
        end
        @(negedge clock);
        load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got done=0 after %0d cycles, expected done=1", budget);
            exp_res.delete();
        end
        @(negedge clock);
    endtask

    // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic load_and_run(input int m, input logic [31:0] halt, input int gapmode,
                                input bit skip_start);
        int k;
        bit to;
        mode = m;
        halt_addr = halt;
        exp_err = 1'b0;
        if (!skip_start) do_start();
        for (int i = 0; i < prog_a.size(); i++) begin
            send(prog_a[i], prog_d[i], i == prog_a.size() - 1,
                 (gapmode == 2) ? int'($urandom_range(0, 2)) : gapmode);
        end
        predict(m, halt, k, to);
        exp_res.push_back('{k, to, exp_err});
        wait_done(200);
        chk("wr_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_widx", 32'(imem_widx), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        @(negedge clock);

        prog_a = '{32'd0, 32'd4, 32'd36};
        prog_d = '{32'h2008_00FF, 32'h0800_0024, 32'h2009_00FF};
        load_and_run(0, 32'd88, 0, 1'b0);
        load_and_run(0, 32'd88, 1, 1'b0);

        prog_a = '{32'd0, 32'h6, IMEM_WORDS * 4, 32'd8, 32'd12};
        prog_d = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        load_and_run(0, 32'd40, 0, 1'b0);

        prog_a = '{32'd0};
        prog_d = '{32'h0800_0000};
        load_and_run(1, 32'h100, 0, 1'b0);

        prog_a = '{32'd0, 32'd4};
        prog_d = '{$urandom, $urandom};
        load_and_run(0, 32'hFFFF_FFF0, 0, 1'b0);
        do_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_timeout", 32'(timeout), 32'd0);
        chk("restart_run_cycles", run_cycles, 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_load_ready", 32'(load_ready), 32'd1);
        // halt lands on the very cycle the budget expires
        load_and_run(0, 32'(4 * (MAX_RUN - 1)), 0, 1'b1);

        prog_a = '{32'd0, 32'h101};
        prog_d = '{$urandom, $urandom};
        load_and_run(0, 32'd88, 0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(3, 6));
            prog_a.delete();
            prog_d.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) prog_a.push_back($urandom);
                else prog_a.push_back(32'(4 * $urandom_range(0, IMEM_WORDS - 1)));
                prog_d.push_back($urandom);
            end
            load_and_run(int'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                     : 32'(4 * $urandom_range(0, 40)),
                         2, 1'b0);
        end

        // reset in the middle of a run aborts straight to IDLE
        prog_a = '{32'd0};
        prog_d = '{$urandom};
        mode = 0;
        halt_addr = 32'hFFFF_FFF0;
        do_start();
        send(prog_a[0], prog_d[0], 1'b1, 0);
        begin
            int n = 0;
            while (cpu_reset && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        chk("run_entered", 32'(cpu_reset), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_run_cycles", run_cycles, 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd0);
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
